ip_fp_addsub_issue: RTL

//  Operand issue stage directly upstream of the FP add/sub datapath. Accepts operand pairs over

---
 rtl/ip_fp_addsub_issue_if.sv | 53 +++++
 rtl/ip_fp_addsub_issue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ip_fp_addsub_issue_if.sv
// ----------------------------------------------------------------------------
// ip_fp_addsub_issue_if
// Handshake bundle between an operand producer, the FP add/sub issue stage
// and the adder that consumes its head entry.
//
//   in_valid / in_ready      operand pair handshake (producer -> issue stage)
//   in_op, in_rnd            0 add / 1 sub, rounding mode
//   in_a, in_b, in_tag       operands and sideband tag
//   out_valid / out_ready    head entry handshake (issue stage -> adder)
//   out_op .. out_tag        registered head entry fields
//   out_special, out_spec_z  special-case flag and bypass result
//   out_invalid              head is an invalid operation
//   occupancy                number of buffered entries (0..2)
//
// The issue stage connects through the slave modport; the producer/consumer
// side (or a bench) uses the master modport.
// ----------------------------------------------------------------------------
interface ip_fp_addsub_issue_if #(
    parameter int P_WORD = 16,
    parameter int P_TAG  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic [2:0]        in_rnd;
    logic [P_WORD-1:0] in_a;
    logic [P_WORD-1:0] in_b;
    logic [P_TAG-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic              out_op;
    logic [2:0]        out_rnd;
    logic [P_WORD-1:0] out_a;
    logic [P_WORD-1:0] out_b;
    logic [P_TAG-1:0]  out_tag;
    logic              out_special;
    logic [P_WORD-1:0] out_spec_z;
    logic              out_invalid;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_op, in_rnd, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_op, out_rnd, out_a, out_b, out_tag,
               out_special, out_spec_z, out_invalid, occupancy
    );

    modport slave (
        input  in_valid, in_op, in_rnd, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_op, out_rnd, out_a, out_b, out_tag,
               out_special, out_spec_z, out_invalid, occupancy
    );
endinterface

// File: rtl/ip_fp_addsub_issue.sv
// ----------------------------------------------------------------------------
// ip_fp_addsub_issue
// Operand issue stage in front of the FP add/sub datapath. Operand pairs are
// accepted over valid/ready, buffered in a 2-entry FIFO and presented as
// registered fields to the adder. IEEE specials (NaN, Inf, zero), which the
// adder does not handle, are classified when an entry is written and the
// special result is carried alongside the entry as a bypass value.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    ip_fp_addsub_issue_if.slave (see interface header for fields)
//
// Every output is a function of registers only: there is no combinational
// path from the in_* side to the out_* side or to in_ready.
// ----------------------------------------------------------------------------
module ip_fp_addsub_issue #(
    parameter int P_EXP  = 5,
    parameter int P_FRAC = 10,
    parameter int P_WORD = 1 + P_EXP + P_FRAC,
    parameter int P_TAG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ip_fp_addsub_issue_if.slave   bus
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // One buffered operand pair together with its precomputed classification.
    typedef struct packed {
        logic              op;
        logic [2:0]        rnd;
        logic [P_WORD-1:0] a;
        logic [P_WORD-1:0] b;
        logic [P_TAG-1:0]  tag;
        logic              special;
        logic              invalid;
        logic [P_WORD-1:0] spec_z;
    } entry_t;

    typedef struct packed {
        logic              special;
        logic              invalid;
        logic [P_WORD-1:0] z;
    } spec_t;

    // ------------------------------------------------------------------------
    // Special-case classification. The checks are ordered by priority: NaN
    // inputs dominate, then infinities, then zeros. Subnormals are ordinary
    // operands for the adder. The b operand enters the sum as (b_sign ^ op),
    // so wherever b (or its sign) is forwarded the effective sign is used.
    // ------------------------------------------------------------------------
    function automatic spec_t classify(
        input logic [P_WORD-1:0] a,
        input logic [P_WORD-1:0] b,
        input logic              op,
        input logic [2:0]        rnd
    );
        logic              a_sign;
        logic              b_sign;
        logic              b_eff_sign;
        logic              eff_sub;
        logic              zero_sign;
        logic [P_EXP-1:0]  a_exp;
        logic [P_EXP-1:0]  b_exp;
        logic [P_FRAC-1:0] a_frac;
        logic [P_FRAC-1:0] b_frac;
        logic              a_nan;
        logic              b_nan;
        logic              a_snan;
        logic              b_snan;
        logic              a_inf;
        logic              b_inf;
        logic              a_zero;
        logic              b_zero;
        logic [P_WORD-1:0] qnan;
        spec_t             r;

        a_sign     = a[P_WORD-1];
        b_sign     = b[P_WORD-1];
        a_exp      = a[P_WORD-2 -: P_EXP];
        b_exp      = b[P_WORD-2 -: P_EXP];
        a_frac     = a[P_FRAC-1:0];
        b_frac     = b[P_FRAC-1:0];
        b_eff_sign = b_sign ^ op;
        eff_sub    = op ^ a_sign ^ b_sign;

        a_nan  = (&a_exp) & (|a_frac);
        b_nan  = (&b_exp) & (|b_frac);
        // A NaN with a clear fraction MSB is signalling.
        a_snan = a_nan & ~a_frac[P_FRAC-1];
        b_snan = b_nan & ~b_frac[P_FRAC-1];
        a_inf  = (&a_exp) & ~(|a_frac);
        b_inf  = (&b_exp) & ~(|b_frac);
        a_zero = ~(|a_exp) & ~(|a_frac);
        b_zero = ~(|b_exp) & ~(|b_frac);

        // Canonical quiet NaN: positive, exponent all ones, fraction MSB only.
        qnan = {1'b0, {P_EXP{1'b1}}, 1'b1, {(P_FRAC-1){1'b0}}};

        // Exact zero sum: round-toward-negative yields -0 unless both are +0.
        if (rnd == 3'b010) begin
            zero_sign = a_sign | b_eff_sign;
        end else begin
            zero_sign = a_sign & b_eff_sign;
        end

        r = '0;
        if (a_nan || b_nan) begin
            r.special = 1'b1;
            r.invalid = a_snan | b_snan;
            r.z       = qnan;
        end else if (a_inf && b_inf && eff_sub) begin
            // Inf - Inf has no meaningful value.
            r.special = 1'b1;
            r.invalid = 1'b1;
            r.z       = qnan;
        end else if (a_inf && b_inf) begin
            r.special = 1'b1;
            r.invalid = 1'b0;
            r.z       = a;
        end else if (a_inf) begin
            r.special = 1'b1;
            r.invalid = 1'b0;
            r.z       = a;
        end else if (b_inf) begin
            r.special = 1'b1;
            r.invalid = 1'b0;
            r.z       = {b_eff_sign, b[P_WORD-2:0]};
        end else if (a_zero && b_zero) begin
            r.special = 1'b1;
            r.invalid = 1'b0;
            r.z       = {zero_sign, {(P_WORD-1){1'b0}}};
        end else if (a_zero) begin
            r.special = 1'b1;
            r.invalid = 1'b0;
            r.z       = {b_eff_sign, b[P_WORD-2:0]};
        end else if (b_zero) begin
            r.special = 1'b1;
            r.invalid = 1'b0;
            r.z       = a;
        end else begin
            r = '0;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t     mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] occ_r;

    logic       push_s;
    logic       pop_s;
    logic       in_ready_s;
    logic       out_valid_s;
    logic [1:0] occ_next_s;
    spec_t      spec_s;
    entry_t     new_entry_s;
    entry_t     head_s;

    // Flow control derives only from the occupancy register.
    assign in_ready_s  = (occ_r != OCC_FULL);
    assign out_valid_s = (occ_r != OCC_EMPTY);
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.out_ready;

    // Classify the incoming pair and assemble the entry to be written.
    always_comb begin
        spec_s              = classify(bus.in_a, bus.in_b, bus.in_op, bus.in_rnd);
        new_entry_s         = '0;
        new_entry_s.op      = bus.in_op;
        new_entry_s.rnd     = bus.in_rnd;
        new_entry_s.a       = bus.in_a;
        new_entry_s.b       = bus.in_b;
        new_entry_s.tag     = bus.in_tag;
        new_entry_s.special = spec_s.special;
        new_entry_s.invalid = spec_s.invalid;
        new_entry_s.spec_z  = spec_s.z;
    end

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_next_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // FIFO storage, 1-bit wrapping pointers and occupancy register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= OCC_EMPTY;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_next_s;
        end
    end

    // Present the head entry; data fields are forced to zero while empty so
    // stale storage never leaks toward the adder.
    always_comb begin
        if (out_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_op      = head_s.op;
    assign bus.out_rnd     = head_s.rnd;
    assign bus.out_a       = head_s.a;
    assign bus.out_b       = head_s.b;
    assign bus.out_tag     = head_s.tag;
    assign bus.out_special = head_s.special;
    assign bus.out_spec_z  = head_s.spec_z;
    assign bus.out_invalid = head_s.invalid;
    assign bus.occupancy   = occ_r;

endmodule
